// File: rtl/nco_tdm.sv
// nco_tdm: time-multiplexed NCO. CHANNELS phase accumulators share one sincos core.
// A free-running slot counter visits one channel per clock. Shadow increment and
// offset registers are copied to the active set at a frame boundary. Accumulators
// can also be cleared (phase sync) at a frame boundary.
// Optional feature macro: NCO_TDM_DITHER_EN adds LFSR dither below the angle LSB
// before truncation.

// Pipelined sincos: quadrant fold, then unrolled CORDIC rotation, then LAT registers.
module nco_tdm_sincos #(
  parameter int ANGLE_W  = 20,
  parameter int OUT_W    = 19,
  parameter int CALCTYPE = 1,
  parameter int LAT      = 4
) (
  input  logic                      i_clk,
  input  logic [ANGLE_W-1:0]        i_angle,
  output logic signed [OUT_W-1:0]   o_cos,
  output logic signed [OUT_W-1:0]   o_sin
);
  localparam int G   = 3;
  localparam int IW  = OUT_W + G + 2;
  localparam int NIT = (OUT_W < 30) ? OUT_W : 30;
  localparam longint AMP = (longint'(1) << (OUT_W - 1)) - 1;
  // Start vector pre-scaled by the CORDIC gain reciprocal (39797/65536 ~ 0.6072529).
  localparam logic signed [IW-1:0] X0  = IW'((AMP * 39797 * (longint'(1) << G)) >>> 16);
  localparam logic signed [IW-1:0] HI  = IW'(AMP);
  localparam logic signed [IW-1:0] LO  = IW'(-AMP - 1);
  // CALCTYPE 0 truncates the guard bits, anything else rounds them.
  localparam logic signed [IW-1:0] RND = (CALCTYPE != 0) ? IW'(longint'(1) << (G - 1)) : '0;

  // atan(2^-i) expressed as a fraction of a full turn, scaled by 2^32
  function automatic logic [31:0] atan_lut(input int i);
    case (i)
      0: return 32'h2000_0000;  1: return 32'h12E4_051D;  2: return 32'h09FB_385B;
      3: return 32'h0511_11D4;  4: return 32'h028B_0D43;  5: return 32'h0145_D7E1;
      6: return 32'h00A2_F61E;  7: return 32'h0051_7C55;  8: return 32'h0028_BE53;
      9: return 32'h0014_5F2E; 10: return 32'h000A_2F98; 11: return 32'h0005_17CC;
     12: return 32'h0002_8BE6; 13: return 32'h0001_45F3; 14: return 32'h0000_A2F9;
     15: return 32'h0000_517C; 16: return 32'h0000_28BE; 17: return 32'h0000_145F;
     18: return 32'h0000_0A2F; 19: return 32'h0000_0517; 20: return 32'h0000_028B;
     21: return 32'h0000_0145; 22: return 32'h0000_00A2; 23: return 32'h0000_0051;
     24: return 32'h0000_0028; 25: return 32'h0000_0014; 26: return 32'h0000_000A;
     27: return 32'h0000_0005; 28: return 32'h0000_0002; 29: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    s = (v + RND) >>> G;
    if (s > HI)      return OUT_W'(HI);
    else if (s < LO) return OUT_W'(LO);
    else             return OUT_W'(s);
  endfunction

  logic [31:0]              w_a32;
  logic                     w_flip;
  logic signed [IW-1:0]     v_x, v_y, v_dx, v_dy;
  logic signed [31:0]       v_z;
  logic signed [OUT_W-1:0]  w_cos, w_sin;
  logic signed [OUT_W-1:0]  r_cos [LAT];
  logic signed [OUT_W-1:0]  r_sin [LAT];

  assign w_a32  = 32'(i_angle) << (32 - ANGLE_W);
  // Quadrants 1 and 2 are folded by 180 degrees and the result negated.
  assign w_flip = w_a32[31] ^ w_a32[30];

  // Combinational CORDIC rotation of (X0, 0) by the folded angle
  always_comb begin
    v_z  = signed'(w_a32 ^ {w_flip, 31'd0});
    v_x  = X0;
    v_y  = '0;
    v_dx = '0;
    v_dy = '0;
    for (int i = 0; i < NIT; i++) begin
      v_dx = v_x >>> i;
      v_dy = v_y >>> i;
      if (!v_z[31]) begin
        v_x = v_x - v_dy;
        v_y = v_y + v_dx;
        v_z = v_z - signed'(atan_lut(i));
      end else begin
        v_x = v_x + v_dy;
        v_y = v_y - v_dx;
        v_z = v_z + signed'(atan_lut(i));
      end
    end
    if (w_flip) begin
      v_x = -v_x;
      v_y = -v_y;
    end
    w_cos = sat_out(v_x);
    w_sin = sat_out(v_y);
  end

  // Output delay line; data is unreset, the caller's valid tag qualifies it
  always_ff @(posedge i_clk) begin
    r_cos[0] <= w_cos;
    r_sin[0] <= w_sin;
    for (int i = 1; i < LAT; i++) begin
      r_cos[i] <= r_cos[i-1];
      r_sin[i] <= r_sin[i-1];
    end
  end

  assign o_cos = r_cos[LAT-1];
  assign o_sin = r_sin[LAT-1];
endmodule

module nco_tdm #(
  parameter int CHANNELS   = 2,
  parameter int ACC_W      = 32,
  parameter int ANGLE_W    = 20,
  parameter int OUT_W      = 19,
  parameter int CALCTYPE   = 1,
  parameter int SINCOS_LAT = 4,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic                     i_wr_sel,
  input  logic [CH_W-1:0]          i_wr_ch,
  input  logic [ACC_W-1:0]         i_wr_data,
  input  logic                     i_commit,
  input  logic                     i_sync,
  output logic                     o_commit_busy,
  output logic                     o_out_valid,
  output logic [CH_W-1:0]          o_out_ch,
  output logic signed [OUT_W-1:0]  o_cos,
  output logic signed [OUT_W-1:0]  o_sin
);
  localparam int L  = 1 + SINCOS_LAT;
  localparam int DW = ACC_W - ANGLE_W;

  if (CHANNELS < 2)                    begin : g_err_ch  $error("CHANNELS must be >= 2"); end
  if (ANGLE_W > ACC_W || ANGLE_W > 32) begin : g_err_aw  $error("ANGLE_W out of range"); end
  if (SINCOS_LAT < 1)                  begin : g_err_lat $error("SINCOS_LAT must be >= 1"); end

  logic [CH_W-1:0]    r_slot;
  logic [ACC_W-1:0]   r_acc     [CHANNELS];
  logic [ACC_W-1:0]   r_inc_sh  [CHANNELS];
  logic [ACC_W-1:0]   r_ofs_sh  [CHANNELS];
  logic [ACC_W-1:0]   r_inc_act [CHANNELS];
  logic [ACC_W-1:0]   r_ofs_act [CHANNELS];
  logic               r_pend_c, r_pend_s;
  logic [ACC_W-1:0]   r_phase_q;
  logic [CH_W-1:0]    r_tag_ch  [L];
  logic               r_tag_v   [L];
  logic               w_boundary, w_apply_c, w_apply_s, w_wr_ok;
  logic [CH_W:0]      w_wr_ch_ext;
  logic [ANGLE_W-1:0] w_angle;

  assign w_boundary  = (r_slot == CH_W'(CHANNELS - 1));
  // A request arriving on the boundary edge itself is honoured at that boundary.
  assign w_apply_c   = r_pend_c | i_commit;
  assign w_apply_s   = r_pend_s | i_sync;
  assign w_wr_ch_ext = {1'b0, i_wr_ch};
  assign w_wr_ok     = i_wr_en && (w_wr_ch_ext < (CH_W+1)'(CHANNELS));

  // Slot counter: one channel per clock, wraps at the end of each frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_slot <= '0;
    else if (w_boundary) r_slot <= '0;
    else                 r_slot <= r_slot + CH_W'(1);
  end

  // Shadow registers take writes immediately; out-of-range channels are dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_inc_sh[i] <= '0;
        r_ofs_sh[i] <= '0;
      end
    end else if (w_wr_ok) begin
      if (i_wr_sel) r_ofs_sh[i_wr_ch] <= i_wr_data;
      else          r_inc_sh[i_wr_ch] <= i_wr_data;
    end
  end

  // Active registers copy the whole shadow set at once, only at a frame boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_inc_act[i] <= '0;
        r_ofs_act[i] <= '0;
      end
    end else if (w_boundary && w_apply_c) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_inc_act[i] <= r_inc_sh[i];
        r_ofs_act[i] <= r_ofs_sh[i];
      end
    end
  end

  // Pending commit/sync flags; merged until the next boundary consumes them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_c <= 1'b0;
      r_pend_s <= 1'b0;
    end else if (w_boundary) begin
      r_pend_c <= 1'b0;
      r_pend_s <= 1'b0;
    end else begin
      r_pend_c <= w_apply_c;
      r_pend_s <= w_apply_s;
    end
  end

  // Phase accumulators: the current slot advances, a boundary sync clears all
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_boundary && w_apply_s)     r_acc[i] <= '0;
        else if (CH_W'(i) == r_slot)     r_acc[i] <= r_acc[i] + r_inc_act[i];
      end
    end
  end

  // Phase sample uses the pre-update accumulator plus the channel offset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_phase_q <= '0;
    else          r_phase_q <= r_acc[r_slot] + r_ofs_act[r_slot];
  end

  // Channel and valid tags delayed by L to line up with sincos output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < L; i++) begin
        r_tag_ch[i] <= '0;
        r_tag_v[i]  <= 1'b0;
      end
    end else begin
      r_tag_ch[0] <= r_slot;
      r_tag_v[0]  <= 1'b1;
      for (int i = 1; i < L; i++) begin
        r_tag_ch[i] <= r_tag_ch[i-1];
        r_tag_v[i]  <= r_tag_v[i-1];
      end
    end
  end

`ifdef NCO_TDM_DITHER_EN
  if (DW > 16) begin : g_err_dw $error("dither needs ACC_W-ANGLE_W <= 16"); end

  localparam logic [ACC_W-1:0] DMASK = (ACC_W'(1) << DW) - ACC_W'(1);
  logic [15:0]      r_lfsr;
  logic [ACC_W-1:0] w_dither;

  // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, free-running
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_dither = ACC_W'(r_lfsr) & DMASK;
  assign w_angle  = ANGLE_W'((r_phase_q + w_dither) >> DW);
`else
  assign w_angle  = ANGLE_W'(r_phase_q >> DW);
`endif

  nco_tdm_sincos #(
    .ANGLE_W  (ANGLE_W),
    .OUT_W    (OUT_W),
    .CALCTYPE (CALCTYPE),
    .LAT      (SINCOS_LAT)
  ) u_sincos (
    .i_clk   (i_clk),
    .i_angle (w_angle),
    .o_cos   (o_cos),
    .o_sin   (o_sin)
  );

  assign o_commit_busy = r_pend_c | r_pend_s;
  assign o_out_valid   = r_tag_v[L-1];
  assign o_out_ch      = r_tag_ch[L-1];
endmodule

// File: tb/tb_nco_tdm.sv
// Scoreboard bench for nco_tdm: a per-channel phase model pushes expected
// (channel, angle) samples; a negedge monitor pops and compares cos/sin.
module tb_nco_tdm;
  localparam int CH     = 3;
  localparam int CHW    = 2;
  localparam int ACC_W  = 32;
  localparam int ANG_W  = 20;
  localparam int OUT_W  = 19;
  localparam int LAT    = 4;
  localparam int L      = LAT + 1;
  localparam int TOL    = 8;
  localparam real PI    = 3.14159265358979;
  localparam real AMPR  = 262143.0;

  logic clk = 0, rst_n = 1;
  logic wr_en = 0, wr_sel = 0, commit = 0, sync = 0;
  logic [CHW-1:0]   wr_ch = 0;
  logic [ACC_W-1:0] wr_data = 0;
  logic busy_o, valid_o;
  logic [CHW-1:0] ch_o;
  logic signed [OUT_W-1:0] cos_o, sin_o;

  always #5 clk = ~clk;

  nco_tdm #(.CHANNELS(CH), .ACC_W(ACC_W), .ANGLE_W(ANG_W), .OUT_W(OUT_W),
            .CALCTYPE(1), .SINCOS_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_sel(wr_sel),
    .i_wr_ch(wr_ch), .i_wr_data(wr_data), .i_commit(commit), .i_sync(sync),
    .o_commit_busy(busy_o), .o_out_valid(valid_o), .o_out_ch(ch_o),
    .o_cos(cos_o), .o_sin(sin_o));

  typedef struct { int ch; int ang; } samp_t;
  samp_t q[$];

  logic [31:0] m_phase [CH];
  logic [31:0] m_inc_sh[CH], m_ofs_sh[CH], m_inc[CH], m_ofs[CH];
  int  m_slot, m_cycles;
  bit  m_req_c, m_req_s;
  int  n_checks = 0, n_err = 0;

  function automatic void chk(input bit ok, input string nm, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int exp_trig(input int ang, input bit want_sin);
    real ph, v;
    ph = 2.0 * PI * real'(ang) / 1048576.0;
    v  = AMPR * (want_sin ? $sin(ph) : $cos(ph));
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_phase[i] = 0; m_inc_sh[i] = 0; m_ofs_sh[i] = 0; m_inc[i] = 0; m_ofs[i] = 0;
    end
    m_slot = 0; m_cycles = 0; m_req_c = 0; m_req_s = 0;
    q.delete();
  endtask

  // One clock of the NCO: emit the current channel's angle, advance its phase,
  // and at the end of a frame apply the outstanding commit/sync requests.
  task automatic model_step();
    logic [31:0] ph;
    samp_t s;
    bool_t_dummy: begin end
    ph    = m_phase[m_slot] + m_ofs[m_slot];
    s.ch  = m_slot;
    s.ang = int'(ph >> (ACC_W - ANG_W));
    q.push_back(s);
    m_phase[m_slot] = m_phase[m_slot] + m_inc[m_slot];
    m_req_c = m_req_c | commit;
    m_req_s = m_req_s | sync;
    if (m_slot == CH - 1) begin
      if (m_req_c) for (int i = 0; i < CH; i++) begin m_inc[i] = m_inc_sh[i]; m_ofs[i] = m_ofs_sh[i]; end
      if (m_req_s) for (int i = 0; i < CH; i++) m_phase[i] = 0;
      m_req_c = 0; m_req_s = 0;
    end
    if (wr_en && int'(wr_ch) < CH) begin
      if (wr_sel) m_ofs_sh[wr_ch] = wr_data;
      else        m_inc_sh[wr_ch] = wr_data;
    end
    m_slot = (m_slot + 1) % CH;
    m_cycles++;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end

  // Monitor: compare every output cycle against the scoreboard
  initial forever begin
    samp_t s;
    int ec, es;
    @(negedge clk);
    chk(busy_o == (m_req_c | m_req_s), "commit_busy", busy_o, m_req_c | m_req_s);
    chk(valid_o == (m_cycles >= L), "out_valid", valid_o, m_cycles >= L);
    if (valid_o) begin
      if (q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL scoreboard_empty: got valid=1 expected no output at %0t", $time);
      end else begin
        s  = q.pop_front();
        ec = exp_trig(s.ang, 0);
        es = exp_trig(s.ang, 1);
        chk(int'(ch_o) == s.ch, "out_ch", ch_o, s.ch);
        chk((int'(cos_o) - ec) <= TOL && (ec - int'(cos_o)) <= TOL, "cos", cos_o, ec);
        chk((int'(sin_o) - es) <= TOL && (es - int'(sin_o)) <= TOL, "sin", sin_o, es);
      end
    end else begin
      chk(ch_o == 0, "out_ch_idle", ch_o, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit sel, input int ch, input logic [31:0] d);
    wr_en = 1; wr_sel = sel; wr_ch = CHW'(ch); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic req(input bit c, input bit s);
    commit = c; sync = s;
    tick();
    commit = 0; sync = 0;
  endtask

  // Next edge will process slot s (bounded: at most one frame)
  task automatic wait_slot(input int s);
    for (int i = 0; i <= CH && m_slot != s; i++) tick();
  endtask

  initial begin
    model_reset();
    #1 rst_n = 0;
    repeat (10) tick();
    chk(valid_o == 0, "reset_valid", valid_o, 0);
    chk(busy_o == 0, "reset_busy", busy_o, 0);
    chk(ch_o == 0, "reset_ch", ch_o, 0);
    rst_n = 1;
    repeat (8) tick();

    // quarter-turn increment on ch0
    wr(0, 0, 32'h4000_0000);
    req(1, 0);
    repeat (15) tick();

    // writes split across two frames, one commit: no partial update
    wait_slot(0);
    wr(0, 0, 32'h1000_0000);
    wait_slot(0);
    wr(0, 1, 32'h0800_0000);
    req(1, 0);
    chk(busy_o == 1, "busy_pending", busy_o, 1);
    repeat (12) tick();

    // commit on the boundary edge takes effect without busy
    wr(0, 1, 32'hFFFF_F000);
    wait_slot(CH - 1);
    req(1, 0);
    chk(busy_o == 0, "busy_on_boundary", busy_o, 0);
    repeat (12) tick();
    wr(0, 1, 32'h8000_0000);
    req(1, 0);
    repeat (10) tick();

    // out-of-range write is ignored
    wr(0, 3, 32'h1234_5678);
    wr(1, 3, 32'h7654_3210);

    // offset, then mid-frame sync
    wr(1, 0, 32'h2000_0000);
    req(1, 0);
    repeat (9) tick();
    wait_slot(1);
    req(0, 1);
    repeat (12) tick();

    // sync and commit on the same boundary
    wr(0, 2, 32'h0123_4567);
    wait_slot(CH - 1);
    req(1, 1);
    repeat (12) tick();

    // reset mid-frame with a commit pending
    wait_slot(0);
    req(1, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk(valid_o == 0, "midreset_valid", valid_o, 0);
    chk(busy_o == 0, "midreset_busy", busy_o, 0);
    chk(ch_o == 0, "midreset_ch", ch_o, 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (12) tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_sel  = $urandom_range(0, 1);
      wr_ch   = CHW'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8191)) << 12 : $urandom;
      commit  = ($urandom_range(0, 11) == 0);
      sync    = ($urandom_range(0, 39) == 0);
      tick();
    end
    wr_en = 0; commit = 0; sync = 0;
    repeat (L + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
